bp_fpga_host_nbf_rx: RTL

Upstream neighbour of the host IO output stage. Takes UART RX bytes from the PC host and assembles them into NBF packets. Executes each packet: memory write/read requests toward BlackParrot, fence, finish. Emits NBF response packets (read data, fence done, finish, error) on the nbf interface consumed by the host IO output stage.

---
 rtl/bp_fpga_host_pkg.sv | 38 +++
 rtl/bp_fpga_host_nbf_assembler.sv | 80 ++++++++
 rtl/bp_fpga_host_nbf_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fpga_host_pkg.sv
// NBF packet definitions shared by the host RX assembler/executor and the IO output stage.
`define BP_FPGA_HOST_NBF_WIDTH(addr_w, data_w) (8 + (addr_w) + (data_w))

`define DECLARE_BP_FPGA_HOST_NBF_S(addr_w, data_w) \
  typedef struct packed { \
    logic [7:0]            opcode; \
    logic [(addr_w)-1:0]   addr; \
    logic [(data_w)-1:0]   data; \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  typedef enum logic [7:0] {
    e_nbf_write_4 = 8'h02,
    e_nbf_write_8 = 8'h03,
    e_nbf_read_4  = 8'h12,
    e_nbf_read_8  = 8'h13,
    e_nbf_error   = 8'hFA,
    e_nbf_fence   = 8'hFE,
    e_nbf_finish  = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  localparam logic [7:0] nbf_err_fifo_full_gp  = 8'h01;
  localparam logic [7:0] nbf_err_timeout_gp    = 8'h02;
  localparam logic [7:0] nbf_err_rx_gp         = 8'h03;
  localparam logic [7:0] nbf_err_bad_opcode_gp = 8'h04;
  localparam logic [7:0] nbf_err_stray_resp_gp = 8'h05;

  function automatic logic nbf_is_mem_op(input logic [7:0] op);
    return (op == e_nbf_write_4) || (op == e_nbf_write_8)
        || (op == e_nbf_read_4)  || (op == e_nbf_read_8);
  endfunction

  function automatic logic nbf_is_read_op(input logic [7:0] op);
    return (op == e_nbf_read_4) || (op == e_nbf_read_8);
  endfunction

endpackage

// File: rtl/bp_fpga_host_nbf_assembler.sv
// Collects UART RX bytes into NBF packets; partial packets are dropped on an RX
// error or after byte_timeout_p idle cycles, each reported as an error pulse.
module bp_fpga_host_nbf_assembler
  import bp_fpga_host_pkg::*;
  #(parameter int nbf_addr_width_p = 40
    , parameter int nbf_data_width_p = 64
    , parameter int uart_data_bits_p = 8
    , parameter int byte_timeout_p   = 2**20
    , localparam int nbf_width_lp = `BP_FPGA_HOST_NBF_WIDTH(nbf_addr_width_p, nbf_data_width_p)
    )
  (input  logic                        clk_i
   , input  logic                        reset_i
   , input  logic                        rx_v_i
   , input  logic [uart_data_bits_p-1:0] rx_data_i
   , input  logic                        rx_error_i
   , output logic [nbf_width_lp-1:0]     pkt_o
   , output logic                        pkt_v_o
   , output logic                        err_v_o
   , output logic [7:0]                  err_code_o
   );

  localparam int nbf_bytes_lp = (nbf_width_lp + uart_data_bits_p - 1) / uart_data_bits_p;
  localparam int buf_width_lp = nbf_bytes_lp * uart_data_bits_p;
  localparam int cnt_width_lp = $clog2(nbf_bytes_lp);
  localparam logic [cnt_width_lp-1:0] last_byte_lp = cnt_width_lp'(nbf_bytes_lp - 1);

  logic [buf_width_lp-1:0] bytes_q, bytes_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [31:0]             timer_q, timer_d;

  // Byte i lands at bits [8i +: 8], so the LSB-first addr/data fields fall out as plain slices.
  always_comb begin
    bytes_d    = bytes_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    pkt_v_o    = 1'b0;
    err_v_o    = 1'b0;
    err_code_o = '0;
    if (rx_error_i) begin
      cnt_d      = '0;
      timer_d    = '0;
      err_v_o    = 1'b1;
      err_code_o = nbf_err_rx_gp;
    end else if (rx_v_i) begin
      bytes_d[cnt_q*uart_data_bits_p +: uart_data_bits_p] = rx_data_i;
      timer_d = '0;
      if (cnt_q == last_byte_lp) begin
        cnt_d   = '0;
        pkt_v_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      timer_d = timer_q + 32'd1;
      if (timer_d == 32'(byte_timeout_p)) begin
        cnt_d      = '0;
        timer_d    = '0;
        err_v_o    = 1'b1;
        err_code_o = nbf_err_timeout_gp;
      end
    end
  end

  assign pkt_o = {bytes_d[0 +: 8]
                  , bytes_d[8 +: nbf_addr_width_p]
                  , bytes_d[8+nbf_addr_width_p +: nbf_data_width_p]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bytes_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/bp_fpga_host_nbf_rx.sv
// Host NBF receive path: assembles packets from UART bytes, executes them as memory
// requests / fence / finish, and returns NBF responses (read data, done, errors).
module bp_fpga_host_nbf_rx
  import bp_fpga_host_pkg::*;
  #(parameter int nbf_addr_width_p  = 40
    , parameter int nbf_data_width_p  = 64
    , parameter int uart_data_bits_p  = 8
    , parameter int max_outstanding_p = 8
    , parameter int byte_timeout_p    = 2**20
    , localparam int nbf_width_lp = `BP_FPGA_HOST_NBF_WIDTH(nbf_addr_width_p, nbf_data_width_p)
    )
  (input  logic                        clk_i
   , input  logic                        reset_i
   , input  logic                        rx_v_i
   , input  logic [uart_data_bits_p-1:0] rx_data_i
   , input  logic                        rx_error_i
   , output logic [nbf_width_lp-1:0]     mem_req_o
   , output logic                        mem_req_v_o
   , input  logic                        mem_req_ready_and_i
   , input  logic                        mem_resp_v_i
   , input  logic [nbf_data_width_p-1:0] mem_resp_data_i
   , output logic [nbf_width_lp-1:0]     nbf_o
   , output logic                        nbf_v_o
   , input  logic                        nbf_ready_and_i
   );

  `DECLARE_BP_FPGA_HOST_NBF_S(nbf_addr_width_p, nbf_data_width_p);

  typedef enum logic [2:0] {e_ready, e_issue, e_read_wait, e_drain, e_send} state_e;

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);

  logic [nbf_width_lp-1:0] asm_pkt;
  logic                    asm_pkt_v, asm_err_v;
  logic [7:0]              asm_err_code;

  bp_fpga_host_nbf_assembler
    #(.nbf_addr_width_p(nbf_addr_width_p)
      , .nbf_data_width_p(nbf_data_width_p)
      , .uart_data_bits_p(uart_data_bits_p)
      , .byte_timeout_p(byte_timeout_p))
    assembler
     (.clk_i(clk_i)
      , .reset_i(reset_i)
      , .rx_v_i(rx_v_i)
      , .rx_data_i(rx_data_i)
      , .rx_error_i(rx_error_i)
      , .pkt_o(asm_pkt)
      , .pkt_v_o(asm_pkt_v)
      , .err_v_o(asm_err_v)
      , .err_code_o(asm_err_code));

  state_e                  state_q, state_d;
  bp_fpga_host_nbf_s       cur_q, cur_d, resp_q, resp_d, fifo_head;
  logic [out_width_lp-1:0] outstanding_q, outstanding_d;
  logic                    err_pend_q, err_pend_d, err_ovf_q, err_ovf_d;
  logic [7:0]              err_code_q, err_code_d;
  logic [nbf_width_lp-1:0] fifo_mem_q [2];
  logic [nbf_width_lp-1:0] fifo_mem_d [2];
  logic                    fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_drop;
  logic                    req_hs, resp_ok, resp_stray, err_inject, err_any, err_multi;
  logic [7:0]              err_new_code;

  // Two-entry packet FIFO; a packet completing while it is full is lost.
  assign fifo_full  = (fifo_cnt_q == 2'd2);
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign fifo_push  = asm_pkt_v & ~fifo_full;
  assign fifo_drop  = asm_pkt_v & fifo_full;
  assign fifo_head  = fifo_mem_q[fifo_rptr_q];

  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (fifo_push) begin
      fifo_mem_d[fifo_wptr_q] = asm_pkt;
      fifo_wptr_d = ~fifo_wptr_q;
    end
    if (fifo_pop) begin
      fifo_rptr_d = ~fifo_rptr_q;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    resp_d      = resp_q;
    fifo_pop    = 1'b0;
    err_inject  = 1'b0;
    mem_req_v_o = 1'b0;
    nbf_v_o     = 1'b0;
    case (state_q)
      e_ready: begin
        // A pending error is reported before any further host packet is executed.
        if (err_pend_q) begin
          err_inject = 1'b1;
          resp_d     = '{opcode: e_nbf_error, addr: '0,
                         data: nbf_data_width_p'({err_ovf_q, err_code_q})};
          state_d    = e_send;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          if (nbf_is_mem_op(fifo_head.opcode)) begin
            state_d = e_issue;
          end else if ((fifo_head.opcode == e_nbf_fence) || (fifo_head.opcode == e_nbf_finish)) begin
            state_d = e_drain;
          end else begin
            resp_d  = '{opcode: e_nbf_error, addr: '0,
                        data: nbf_data_width_p'(nbf_err_bad_opcode_gp)};
            state_d = e_send;
          end
        end
      end
      e_issue: begin
        mem_req_v_o = (outstanding_q < out_width_lp'(max_outstanding_p));
        if (mem_req_v_o && mem_req_ready_and_i) begin
          state_d = nbf_is_read_op(cur_q.opcode) ? e_read_wait : e_ready;
        end
      end
      e_read_wait: begin
        // Responses return in order, so the one that empties the counter is our read.
        if (mem_resp_v_i && (outstanding_q == out_width_lp'(1))) begin
          resp_d      = cur_q;
          resp_d.data = mem_resp_data_i;
          state_d     = e_send;
        end
      end
      e_drain: begin
        if (outstanding_q == '0) begin
          resp_d  = '{opcode: cur_q.opcode, addr: '0, data: '0};
          state_d = e_send;
        end
      end
      e_send: begin
        nbf_v_o = 1'b1;
        if (nbf_ready_and_i) begin
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  assign req_hs     = mem_req_v_o & mem_req_ready_and_i;
  assign resp_ok    = mem_resp_v_i & (outstanding_q != '0);
  assign resp_stray = mem_resp_v_i & (outstanding_q == '0);

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_hs, resp_ok})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Single-slot error latch: the first error is kept, anything after only sets overflow.
  assign err_any   = fifo_drop | asm_err_v | resp_stray;
  assign err_multi = (fifo_drop & asm_err_v) | (fifo_drop & resp_stray) | (asm_err_v & resp_stray);
  assign err_new_code = fifo_drop ? nbf_err_fifo_full_gp
                      : asm_err_v ? asm_err_code
                      : nbf_err_stray_resp_gp;

  always_comb begin
    err_pend_d = err_pend_q;
    err_code_d = err_code_q;
    err_ovf_d  = err_ovf_q;
    if (err_inject) begin
      err_pend_d = 1'b0;
      err_ovf_d  = 1'b0;
    end
    if (err_any) begin
      if (err_pend_d) begin
        err_ovf_d = 1'b1;
      end else begin
        err_pend_d = 1'b1;
        err_code_d = err_new_code;
        err_ovf_d  = err_multi;
      end
    end
  end

  assign mem_req_o = cur_q;
  assign nbf_o     = resp_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_ready;
      cur_q         <= '0;
      resp_q        <= '0;
      outstanding_q <= '0;
      err_pend_q    <= 1'b0;
      err_code_q    <= '0;
      err_ovf_q     <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wptr_q   <= 1'b0;
      fifo_rptr_q   <= 1'b0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      resp_q        <= resp_d;
      outstanding_q <= outstanding_d;
      err_pend_q    <= err_pend_d;
      err_code_q    <= err_code_d;
      err_ovf_q     <= err_ovf_d;
      fifo_mem_q    <= fifo_mem_d;
      fifo_wptr_q   <= fifo_wptr_d;
      fifo_rptr_q   <= fifo_rptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

endmodule
